rf_write_queue: RTL and testbench
=================================

RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued write entries; only 4 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_val  input  1  producer write request valid.
REQ-005 SHALL have port in_rdy  output  1  queue can accept a request.
REQ-006 SHALL have port in_addr  input  3  destination register of the request.
REQ-007 SHALL have port in_data  input  8  write data of the request.
REQ-008 SHALL have port wb_stall  input  1  when 1, blocks draining to the register file.
REQ-009 SHALL have ports wb_en, wb_addr, wb_data  output  1/3/8  drive the 8x8b register file write port.
REQ-010 SHALL have ports lk_addr0, lk_addr1  input  3  lookup addresses, tied to the register file read addresses.
REQ-011 SHALL have ports lk_hit0, lk_hit1  output  1  a pending queued write matches the lookup address.
REQ-012 SHALL have ports lk_data0, lk_data1  output  8  data of the matching pending write.
REQ-013 SHALL have port count  output  3  number of valid entries, 0..4.

Function
REQ-014 SHALL hold entries in a circular FIFO with head/tail pointers that wrap modulo 4.
REQ-015 SHALL assert in_rdy = (count < 4), combinationally from state only.
REQ-016 SHALL accept a request on a rising edge when in_val && in_rdy.
REQ-017 SHALL drop an accepted request with in_addr == 0 (no allocation, count unchanged); the register file holds register 0 at zero.
REQ-018 SHALL allocate one tail entry for each accepted request with in_addr != 0.
REQ-019 SHALL drive wb_en = (count != 0) && !wb_stall, with wb_addr/wb_data taken from the head entry.
REQ-020 SHALL pop the head entry on the edge where wb_en is 1.
REQ-021 SHALL give a minimum latency of one cycle: a request accepted at edge N appears on wb_* after edge N, and the register file is written at edge N+1; there is no same-cycle bypass to wb_*.
REQ-022 SHALL, on a simultaneous accept and pop, leave count unchanged and preserve FIFO order.
REQ-023 SHALL never accept a request at count 4, even if a pop occurs in the same cycle.
REQ-024 SHALL make the lookup combinational: lk_hitN = 1 iff any valid entry has address lk_addrN; lk_dataN = data of the youngest such entry; otherwise lk_hitN = 0 and lk_dataN = 0.
REQ-025 SHALL, for lk_addrN == 0, always drive lk_hitN = 0 and lk_dataN = 0.
REQ-026 SHALL count the head entry as a lookup hit in the cycle it is being popped.

Reset
REQ-027 SHALL, while reset_n = 0 and independent of clk, force count = 0, head = tail = 0, wb_en = 0, in_rdy = 1, lk_hit0 = lk_hit1 = 0 and lk_data0 = lk_data1 = 0.
REQ-028 SHALL discard all pending entries when reset is asserted mid-operation; entry storage SHALL NOT be reset.

Configuration
REQ-029 SHALL, with RF_WQ_COALESCE_EN defined, overwrite the youngest entry's data in place (count unchanged) when an accepted nonzero in_addr equals that entry's address and the entry is not being popped this edge.
REQ-030 SHALL, without RF_WQ_COALESCE_EN, allocate a new entry for every accepted nonzero request; in_rdy is identical in both builds.

Verification
REQ-031 SHALL cover: after reset, enqueue (3,0xab) -> next cycle wb_en=1, wb_addr=3, wb_data=0xab, count=1; following cycle count=0, wb_en=0.
REQ-032 SHALL cover: wb_stall=1, enqueue (1,0x11),(2,0x22),(3,0x33),(4,0x44) -> count=4, in_rdy=0, fifth request held; wb_stall=0 -> wb_addr 1,2,3,4 on consecutive cycles.
REQ-033 SHALL cover: wb_stall=1, enqueue (5,0x10),(5,0x20); lk_addr0=5, lk_addr1=6 -> lk_hit0=1, lk_data0=0x20, lk_hit1=0, lk_data1=0; count=2 without RF_WQ_COALESCE_EN and 1 with it.
REQ-034 SHALL cover: enqueue (0,0xff) -> accepted with in_rdy=1, count stays 0, wb_en stays 0; lk_addr0=0 -> lk_hit0=0, lk_data0=0.
REQ-035 SHALL cover: count=4 with wb_stall=0 and in_val=1 -> no accept, count becomes 3; next cycle accept and pop together -> count stays 3 and order is preserved.
REQ-036 SHALL cover: count=3, reset_n driven low between clock edges -> count=0 and wb_en=0 immediately; after release, the first new enqueue drains first.

Source files
------------

// File: rtl/rf_write_queue.sv
// Register-file write queue: 4-entry FIFO of pending (addr, data) writes that drains to
// an 8x8b register file. It gives read-side forwarding through two lookup ports. Optional
// build macro RF_WQ_COALESCE_EN merges a write into the youngest entry when the addresses match.
module rf_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [2:0] in_addr,
    input  logic [7:0] in_data,
    input  logic       wb_stall,
    output logic       wb_en,
    output logic [2:0] wb_addr,
    output logic [7:0] wb_data,
    input  logic [2:0] lk_addr0,
    input  logic [2:0] lk_addr1,
    output logic       lk_hit0,
    output logic       lk_hit1,
    output logic [7:0] lk_data0,
    output logic [7:0] lk_data1,
    output logic [2:0] count
);

    logic [2:0] entry_addr [0:DEPTH-1];
    logic [7:0] entry_data [0:DEPTH-1];

    logic [1:0] head_reg, tail_reg;
    logic [2:0] count_reg, count_next;
    logic [1:0] youngest;
    logic       accept, pop, alloc, coalesce;

    logic [DEPTH-1:0] entry_valid, match0, match1;

    assign count    = count_reg;
    assign in_rdy   = (count_reg < 3'(DEPTH));
    assign wb_en    = (count_reg != 3'd0) && !wb_stall;
    assign wb_addr  = entry_addr[head_reg];
    assign wb_data  = entry_data[head_reg];
    assign pop      = wb_en;
    assign accept   = in_val && in_rdy;
    assign youngest = tail_reg - 2'd1;

`ifdef RF_WQ_COALESCE_EN
    // Merge only if the youngest entry survives this edge; a popped entry is already committed.
    assign coalesce = accept && (in_addr != 3'd0) && (count_reg != 3'd0)
                      && (entry_addr[youngest] == in_addr)
                      && !(pop && (count_reg == 3'd1));
`else
    assign coalesce = 1'b0;
`endif

    // Writes to register 0 are accepted but discarded.
    assign alloc = accept && (in_addr != 3'd0) && !coalesce;

    assign count_next = count_reg + 3'(alloc) - 3'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= 2'd0;
            tail_reg  <= 2'd0;
            count_reg <= 3'd0;
        end else begin
            if (alloc) tail_reg <= tail_reg + 2'd1;
            if (pop)   head_reg <= head_reg + 2'd1;
            count_reg <= count_next;
        end
    end

    // Entry storage is deliberately left out of reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (alloc) begin
            entry_addr[tail_reg] <= in_addr;
            entry_data[tail_reg] <= in_data;
        end else if (coalesce) begin
            entry_data[youngest] <= in_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [1:0] age;
            assign age             = 2'(gi) - head_reg;
            assign entry_valid[gi] = ({1'b0, age} < count_reg);
            assign match0[gi]      = entry_valid[gi] && (lk_addr0 != 3'd0) && (entry_addr[gi] == lk_addr0);
            assign match1[gi]      = entry_valid[gi] && (lk_addr1 != 3'd0) && (entry_addr[gi] == lk_addr1);
        end
    endgenerate

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin : lookup
        logic [1:0] scan_idx;
        scan_idx = head_reg;
        lk_hit0  = 1'b0;
        lk_hit1  = 1'b0;
        lk_data0 = 8'd0;
        lk_data1 = 8'd0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + 2'(k);
            if (match0[scan_idx]) begin
                lk_hit0  = 1'b1;
                lk_data0 = entry_data[scan_idx];
            end
            if (match1[scan_idx]) begin
                lk_hit1  = 1'b1;
                lk_data1 = entry_data[scan_idx];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: directed scenarios plus random traffic against a
// queue-based reference model (RF_WQ_COALESCE_EN selects the merging model).
module tb_rf_write_queue;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_val, in_rdy;
    logic [2:0] in_addr;
    logic [7:0] in_data;
    logic       wb_stall, wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic [2:0] lk_addr0, lk_addr1;
    logic       lk_hit0, lk_hit1;
    logic [7:0] lk_data0, lk_data1;
    logic [2:0] count;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } entry_t;

    entry_t model_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    rf_write_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_val(in_val), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
        .wb_stall(wb_stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .lk_addr0(lk_addr0), .lk_addr1(lk_addr1),
        .lk_hit0(lk_hit0), .lk_hit1(lk_hit1), .lk_data0(lk_data0), .lk_data1(lk_data1),
        .count(count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Youngest pending write to address a, or a miss; register 0 never hits.
    function automatic void model_lookup(input logic [2:0] a, output logic hit, output logic [7:0] d);
        hit = 1'b0;
        d   = 8'd0;
        if (a == 3'd0) return;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].a == a) begin
                hit = 1'b1;
                d   = model_q[i].d;
                return;
            end
        end
    endfunction

    // Called at a negedge: apply inputs, compare, cross the posedge, update the model.
    task automatic step(input logic v, input logic [2:0] a, input logic [7:0] d,
                        input logic st, input logic [2:0] l0, input logic [2:0] l1);
        logic   e_hit0, e_hit1, e_pop, e_acc, merged;
        logic [7:0] e_d0, e_d1;
        int     sz;
        in_val = v; in_addr = a; in_data = d; wb_stall = st; lk_addr0 = l0; lk_addr1 = l1;
        #1;
        sz    = model_q.size();
        e_pop = (sz != 0) && !st;
        e_acc = v && (sz < 4);
        model_lookup(l0, e_hit0, e_d0);
        model_lookup(l1, e_hit1, e_d1);
        check("count", 32'(count), 32'(sz));
        check("in_rdy", 32'(in_rdy), 32'(sz < 4));
        check("wb_en", 32'(wb_en), 32'(e_pop));
        if (sz != 0) begin
            check("wb_addr", 32'(wb_addr), 32'(model_q[0].a));
            check("wb_data", 32'(wb_data), 32'(model_q[0].d));
        end
        check("lk_hit0", 32'(lk_hit0), 32'(e_hit0));
        check("lk_data0", 32'(lk_data0), 32'(e_d0));
        check("lk_hit1", 32'(lk_hit1), 32'(e_hit1));
        check("lk_data1", 32'(lk_data1), 32'(e_d1));
        @(posedge clk);
        merged = 1'b0;
        if (e_acc && a != 3'd0) begin
`ifdef RF_WQ_COALESCE_EN
            if (sz > 0 && model_q[sz-1].a == a && !(e_pop && sz == 1)) begin
                model_q[sz-1].d = d;
                merged = 1'b1;
            end
`endif
            if (!merged) model_q.push_back('{a: a, d: d});
        end
        if (e_pop) void'(model_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        in_val = 0; in_addr = 0; in_data = 0; wb_stall = 0; lk_addr0 = 0; lk_addr1 = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Single write drains one cycle after acceptance.
        step(1, 3'd3, 8'hab, 0, 3'd3, 3'd0);
        check("lat_wb_addr", 32'(wb_addr), 32'd3);
        step(0, 3'd0, 8'h00, 0, 3'd3, 3'd0);
        step(0, 3'd0, 8'h00, 0, 3'd3, 3'd0);

        // Fill while stalled, hold the fifth, then drain in order.
        step(1, 3'd1, 8'h11, 1, 3'd1, 3'd4);
        step(1, 3'd2, 8'h22, 1, 3'd1, 3'd4);
        step(1, 3'd3, 8'h33, 1, 3'd1, 3'd4);
        step(1, 3'd4, 8'h44, 1, 3'd1, 3'd4);
        check("full_in_rdy", 32'(in_rdy), 32'd0);
        step(1, 3'd5, 8'h55, 1, 3'd2, 3'd3);
        // Full and draining: no accept even with a pop in the same cycle.
        step(1, 3'd6, 8'h66, 0, 3'd2, 3'd3);
        step(1, 3'd7, 8'h77, 0, 3'd7, 3'd3);
        repeat (4) step(0, 3'd0, 8'h00, 0, 3'd7, 3'd4);

        // Two writes to the same register: lookup returns the younger one.
        step(1, 3'd5, 8'h10, 1, 3'd5, 3'd6);
        step(1, 3'd5, 8'h20, 1, 3'd5, 3'd6);
        check("dup_lk_data0", 32'(lk_data0), 32'h20);
        step(0, 3'd0, 8'h00, 1, 3'd5, 3'd6);
        repeat (3) step(0, 3'd0, 8'h00, 0, 3'd5, 3'd6);

        // Register 0 write is dropped.
        step(1, 3'd0, 8'hff, 0, 3'd0, 3'd0);
        step(0, 3'd0, 8'h00, 0, 3'd0, 3'd0);

        // Asynchronous reset mid-operation.
        step(1, 3'd1, 8'ha1, 1, 3'd1, 3'd2);
        step(1, 3'd2, 8'ha2, 1, 3'd1, 3'd2);
        step(1, 3'd3, 8'ha3, 1, 3'd1, 3'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_wb_en", 32'(wb_en), 32'd0);
        check("arst_in_rdy", 32'(in_rdy), 32'd1);
        check("arst_lk_hit0", 32'(lk_hit0), 32'd0);
        check("arst_lk_data0", 32'(lk_data0), 32'd0);
        model_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 3'd6, 8'h66, 0, 3'd1, 3'd6);
        check("post_rst_wb_addr", 32'(wb_addr), 32'd6);
        step(0, 3'd0, 8'h00, 0, 3'd1, 3'd6);

        // Random traffic; small address range keeps duplicates and merges frequent.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
